// File: rtl/fetch_unit.sv
// fetch_unit: RV32I instruction fetch stage feeding decode.
// Issues one word read at a time to instruction memory. Each returned word
// is buffered with its PC in a small FIFO that is presented to decode over a
// valid/ready handshake. A redirect from execute flushes the FIFO. It also
// drops the response of any read that is still in flight.
// Optional feature macro: FETCH_FAULT_EN adds imem_err / instr_fault. This
// stores a per-entry bus error and presents it alongside the head.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
`ifdef FETCH_FAULT_EN
  input  logic        imem_err,
  output logic        instr_fault,
`endif
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_WAIT,
    S_DISCARD
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        reqPc_q, reqPc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;

  logic [31:0]        wordMem [FIFO_DEPTH];
  logic [31:0]        pcMem   [FIFO_DEPTH];
`ifdef FETCH_FAULT_EN
  logic               faultMem [FIFO_DEPTH];
`endif

  logic               issue;
  logic               push;
  logic               pop;
  logic               unusedRedirectLsb;

  // Word alignment is forced on redirect, so the low address bits are ignored.
  assign unusedRedirectLsb = ^redirect_pc[1:0];

  assign imem_req  = (state_q == S_RUN) && (count_q < CNT_W'(FIFO_DEPTH));
  assign imem_addr = pc_q;
  assign issue     = imem_req && imem_gnt;
  assign push      = (state_q == S_WAIT) && imem_rvalid && !redirect_valid;
  assign pop       = instr_valid && instr_ready && !redirect_valid;

  assign instr_valid = (count_q != '0);
  assign instr       = wordMem[rdPtr_q];
  assign instr_pc    = pcMem[rdPtr_q];
`ifdef FETCH_FAULT_EN
  assign instr_fault = instr_valid && faultMem[rdPtr_q];
`endif

  // Fetch FSM next state and PC. A redirect overrides the PC and turns any
  // read that is still owed to us into a discarded one.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    reqPc_d = reqPc_q;
    case (state_q)
      S_IDLE:    state_d = S_RUN;
      S_RUN: begin
        if (issue) begin
          state_d = S_WAIT;
          pc_d    = pc_q + 32'd4;
          reqPc_d = pc_q;
        end
      end
      S_WAIT:    if (imem_rvalid) state_d = S_RUN;
      S_DISCARD: if (imem_rvalid) state_d = S_RUN;
      default:   state_d = S_IDLE;
    endcase
    if (redirect_valid) begin
      pc_d = {redirect_pc[31:2], 2'b00};
      if ((state_q == S_RUN) && issue) begin
        state_d = S_DISCARD;
      end else if ((state_q == S_WAIT) && !imem_rvalid) begin
        state_d = S_DISCARD;
      end
    end
  end

  // FIFO occupancy and pointers; a redirect empties the buffer outright.
  always_comb begin
    count_d = count_q;
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (redirect_valid) begin
      count_d = '0;
      wrPtr_d = '0;
      rdPtr_d = '0;
    end else begin
      if (push) wrPtr_d = wrPtr_q + PTR_W'(1);
      if (pop)  rdPtr_d = rdPtr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Control registers, cleared immediately on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      reqPc_q <= '0;
      count_q <= '0;
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      reqPc_q <= reqPc_d;
      count_q <= count_d;
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  // Buffer storage; contents are only meaningful while counted as valid.
  always_ff @(posedge clk) begin
    if (push) begin
      wordMem[wrPtr_q] <= imem_rdata;
      pcMem[wrPtr_q]   <= reqPc_q;
`ifdef FETCH_FAULT_EN
      faultMem[wrPtr_q] <= imem_err;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a one-outstanding
// instruction memory model. Memory words are addr ^ 32'h1357_9BDF.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
`ifdef FETCH_FAULT_EN
  logic        imem_err;
  logic        instr_fault;
`endif
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
    logic        fault;
  } popRec_t;

  popRec_t     popLog[$];
  logic [31:0] addrLog[$];

  int          vectors = 0;
  int          miscompares = 0;
  int          latency = 1;
  bit          gntOn = 1'b1;
  bit          pending = 1'b0;
  logic [31:0] pendAddr = '0;
  int          waitCnt = 0;
  logic [31:0] errAddr = 32'h1;

  fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .FIFO_DEPTH(2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
`ifdef FETCH_FAULT_EN
    .imem_err      (imem_err),
    .instr_fault   (instr_fault),
`endif
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_ready   (instr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return addr ^ 32'h1357_9BDF;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // One clock: drive memory at the negedge, log handshakes, advance the model.
  task automatic applyStimulus();
    bit          respNow;
    bit          reqNow;
    logic [31:0] addrNow;
    popRec_t     rec;
    @(negedge clk);
    respNow     = pending && (waitCnt == 0);
    imem_gnt    = gntOn;
    imem_rvalid = respNow;
    imem_rdata  = respNow ? memWord(pendAddr) : 32'h0;
`ifdef FETCH_FAULT_EN
    imem_err    = respNow && (pendAddr == errAddr);
`endif
    #1;
    reqNow  = imem_req && imem_gnt;
    addrNow = imem_addr;
    if (instr_valid && instr_ready && !redirect_valid) begin
      rec.pc    = instr_pc;
      rec.word  = instr;
`ifdef FETCH_FAULT_EN
      rec.fault = instr_fault;
`else
      rec.fault = 1'b0;
`endif
      popLog.push_back(rec);
    end
    @(posedge clk);
    if (respNow) pending = 1'b0;
    else if (pending) waitCnt--;
    if (reqNow) begin
      checkOutput("oneOutstanding", {31'b0, pending}, 32'h0);
      pending  = 1'b1;
      pendAddr = addrNow;
      waitCnt  = latency - 1;
      addrLog.push_back(addrNow);
    end
    #1;
  endtask

  task automatic resetDut();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b0;
    gntOn          = 1'b1;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
`ifdef FETCH_FAULT_EN
    imem_err       = 1'b0;
`endif
    pending = 1'b0;
    latency = 1;
    errAddr = 32'h1;
    addrLog.delete();
    popLog.delete();
    #1;
    checkOutput("rstReq", {31'b0, imem_req}, 32'h0);
    checkOutput("rstValid", {31'b0, instr_valid}, 32'h0);
`ifdef FETCH_FAULT_EN
    checkOutput("rstFault", {31'b0, instr_fault}, 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic checkPop(input int idx, input logic [31:0] pc, input string tag);
    if (idx < popLog.size()) begin
      checkOutput({tag, "Pc"}, popLog[idx].pc, pc);
      checkOutput({tag, "Word"}, popLog[idx].word, memWord(pc));
    end else begin
      checkOutput({tag, "Missing"}, popLog.size(), idx + 1);
    end
  endtask

  task automatic checkAddr(input int idx, input logic [31:0] addr, input string tag);
    if (idx < addrLog.size()) checkOutput(tag, addrLog[idx], addr);
    else checkOutput({tag, "Missing"}, addrLog.size(), idx + 1);
  endtask

  task automatic checkNoPc(input logic [31:0] pc, input string tag);
    int hits = 0;
    foreach (popLog[i]) if (popLog[i].pc == pc) hits++;
    checkOutput(tag, hits, 0);
  endtask

  task automatic waitForReq(input logic [31:0] addr, input int maxCycles, input string tag);
    bit found = 1'b0;
    for (int i = 0; i < maxCycles && !found; i++) begin
      if (imem_req && imem_addr == addr) found = 1'b1;
      else applyStimulus();
    end
    checkOutput(tag, {31'b0, found}, 32'h1);
  endtask

  // Directed scenarios, each starting from a fresh reset.
  initial begin
    rst_n = 1'b1;
    #2;

    // Streaming with 1-cycle memory and decode always ready.
    resetDut();
    instr_ready = 1'b1;
    applyStimulus();
    checkOutput("t1WaitNoReq", {31'b0, imem_req}, 32'h0);
    applyStimulus();
    checkOutput("t1Valid", {31'b0, instr_valid}, 32'h1);
    checkOutput("t1HeadPc", instr_pc, 32'h0);
    checkOutput("t1HeadWord", instr, memWord(32'h0));
    repeat (6) applyStimulus();
    checkAddr(0, 32'h0, "t1Addr0");
    checkAddr(1, 32'h4, "t1Addr1");
    checkAddr(2, 32'h8, "t1Addr2");
    checkPop(0, 32'h0, "t1Pop0");
    checkPop(1, 32'h4, "t1Pop1");
    checkPop(2, 32'h8, "t1Pop2");

    // Backpressure: two entries buffered, then drain and resume at 0x8.
    resetDut();
    repeat (10) applyStimulus();
    checkOutput("t2Issued", addrLog.size(), 2);
    checkOutput("t2FullNoReq", {31'b0, imem_req}, 32'h0);
    checkOutput("t2HeadPc", instr_pc, 32'h0);
    instr_ready = 1'b1;
    applyStimulus();
    checkOutput("t2NextPc", instr_pc, 32'h4);
    checkOutput("t2Resume", {31'b0, imem_req}, 32'h1);
    checkOutput("t2ResumeAddr", imem_addr, 32'h8);
    repeat (3) applyStimulus();
    checkPop(0, 32'h0, "t2Pop0");
    checkPop(1, 32'h4, "t2Pop1");
    checkPop(2, 32'h8, "t2Pop2");

    // Redirect while waiting on PC 0x8, stale response 3 cycles after gnt.
    resetDut();
    instr_ready = 1'b1;
    latency = 3;
    waitForReq(32'h8, 20, "t3ReachReq8");
    applyStimulus();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    applyStimulus();
    redirect_valid = 1'b0;
    applyStimulus();
    checkOutput("t3DiscardNoReq", {31'b0, imem_req}, 32'h0);
    applyStimulus();
    checkOutput("t3NewReq", {31'b0, imem_req}, 32'h1);
    checkOutput("t3NewAddr", imem_addr, 32'h100);
    repeat (6) applyStimulus();
    checkAddr(3, 32'h100, "t3Addr3");
    checkNoPc(32'h8, "t3No8");
    checkPop(2, 32'h100, "t3Pop2");

    // Redirect coinciding with gnt for PC 0xC.
    resetDut();
    instr_ready = 1'b1;
    waitForReq(32'hC, 20, "t4ReachReqC");
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    applyStimulus();
    redirect_valid = 1'b0;
    checkOutput("t4Flushed", {31'b0, instr_valid}, 32'h0);
    checkOutput("t4DiscardNoReq", {31'b0, imem_req}, 32'h0);
    applyStimulus();
    checkOutput("t4NewReq", {31'b0, imem_req}, 32'h1);
    checkOutput("t4NewAddr", imem_addr, 32'h200);
    repeat (3) applyStimulus();
    checkAddr(3, 32'hC, "t4AddrC");
    checkAddr(4, 32'h200, "t4Addr200");
    checkNoPc(32'h8, "t4No8");
    checkNoPc(32'hC, "t4NoC");
    checkPop(2, 32'h200, "t4Pop2");

    // Unaligned redirect with a full FIFO and decode ready.
    resetDut();
    repeat (10) applyStimulus();
    checkOutput("t5Full", {31'b0, instr_valid}, 32'h1);
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    applyStimulus();
    redirect_valid = 1'b0;
    checkOutput("t5Flushed", {31'b0, instr_valid}, 32'h0);
    checkOutput("t5NoPop", popLog.size(), 0);
    checkOutput("t5NewReq", {31'b0, imem_req}, 32'h1);
    checkOutput("t5NewAddr", imem_addr, 32'h200);
    repeat (3) applyStimulus();
    checkPop(0, 32'h200, "t5Pop0");

    // Redirect without gnt to the top word; PC wraps to zero.
    resetDut();
    instr_ready    = 1'b1;
    errAddr        = 32'hFFFF_FFFC;
    gntOn          = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    applyStimulus();
    gntOn          = 1'b1;
    redirect_valid = 1'b0;
    checkOutput("t6Req", {31'b0, imem_req}, 32'h1);
    checkOutput("t6Addr", imem_addr, 32'hFFFF_FFFC);
    repeat (5) applyStimulus();
    checkAddr(0, 32'hFFFF_FFFC, "t6Addr0");
    checkAddr(1, 32'h0, "t6Addr1");
    checkPop(0, 32'hFFFF_FFFC, "t6Pop0");
    checkPop(1, 32'h0, "t6Pop1");
`ifdef FETCH_FAULT_EN
    if (popLog.size() >= 2) begin
      checkOutput("t6Fault0", {31'b0, popLog[0].fault}, 32'h1);
      checkOutput("t6Fault1", {31'b0, popLog[1].fault}, 32'h0);
    end else begin
      checkOutput("t6FaultMissing", popLog.size(), 2);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
